// File: rtl/key_pkg.sv
// key_pkg: shared key code and pacing-state types for the keypad event queue
package key_pkg;

    typedef logic [3:0] key_code_t;

    typedef enum logic {IDLE, HOLD} kq_state_t;

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small key FIFO with explicit count; KEY_QUEUE_DROP_OLDEST_EN makes a full push evict the head
module key_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [3:0]    din_i,
    output logic [3:0]    dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);

    key_code_t       mem_q [DEPTH];
    logic [PW-1:0]   rd_q, wr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en, rd_adv;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

`ifdef KEY_QUEUE_DROP_OLDEST_EN
    assign wr_en  = push_i;
    assign rd_adv = pop_i | (push_i & full_o);
`else
    assign wr_en  = push_i & (~full_o | pop_i);
    assign rd_adv = pop_i;
`endif

    // count moves only when exactly one of write/advance happens
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !rd_adv) cnt_d = cnt_q + 1'b1;
        else if (rd_adv && !wr_en) cnt_d = cnt_q - 1'b1;
    end

    // pointers and count, flushed synchronously, zeroed asynchronously
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_adv) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // storage needs no reset; only the count says what is valid
    always_ff @(posedge clk) begin
        if (wr_en && !flush_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/key_queue.sv
// key_queue: queues key strobes and paces two-digit display shifts; KEY_QUEUE_DROP_OLDEST_EN selects evict-oldest on overflow
module key_queue
    import key_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    output logic [3:0]                   digit_new,
    output logic [3:0]                   digit_old,
    output logic                         shift_strobe,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    kq_state_t     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    key_code_t     new_q, new_d, old_q, old_d, head;
    logic          strobe_q, strobe_d, ovf_q, ovf_d;
    logic          push, pop, full, empty;

    assign push = key_valid & ~clear;
    assign pop  = (state_q == IDLE) & ~empty & ~clear;

    key_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_ni  (reset),
        .flush_i (clear),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (key_code),
        .dout_o  (head),
        .count_o (fifo_count),
        .full_o  (full),
        .empty_o (empty)
    );

    // pacing FSM: pop into the digits from IDLE, then dwell HOLD_CYCLES edges
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        new_d    = new_q;
        old_d    = old_q;
        strobe_d = 1'b0;
        ovf_d    = ovf_q | (push & full & ~pop);
        if (clear) begin
            state_d = IDLE;
            hold_d  = '0;
            new_d   = '0;
            old_d   = '0;
            ovf_d   = 1'b0;
        end else if (pop) begin
            old_d    = new_q;
            new_d    = head;
            strobe_d = 1'b1;
            hold_d   = '0;
            state_d  = HOLD;
        end else if (state_q == HOLD) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = IDLE;
        end
    end

    // display and pacing registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            new_q    <= '0;
            old_q    <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            new_q    <= new_d;
            old_q    <= old_d;
            strobe_q <= strobe_d;
            ovf_q    <= ovf_d;
        end
    end

    assign digit_new    = new_q;
    assign digit_old    = old_q;
    assign shift_strobe = strobe_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_key_queue.sv
// tb_key_queue: directed checks of key_queue with DEPTH=4, HOLD_CYCLES=4; honours KEY_QUEUE_DROP_OLDEST_EN
module tb_key_queue;
    import key_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] digit_new, digit_old;
    logic       shift_strobe, overflow;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;

    logic [3:0] seq [8];
    int         nseq;
    int         s_edge [16];
    logic [3:0] s_new [16];
    logic [3:0] s_old [16];
    int         ns;
    logic [2:0] cnt_at5;
    logic       ovf_at5;

    key_queue #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .digit_new    (digit_new),
        .digit_old    (digit_old),
        .shift_strobe (shift_strobe),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // drive seq[0..nseq-1] on edges 0.. and log every strobe with its edge number
    task run_seq(input int ncyc);
        ns = 0;
        for (int e = 0; e < ncyc; e++) begin
            key_valid = 1'b0;
            key_code  = 4'h0;
            if (e < nseq) begin
                key_valid = 1'b1;
                key_code  = seq[e];
            end
            tick();
            key_valid = 1'b0;
            if (e == 5) begin
                cnt_at5 = fifo_count;
                ovf_at5 = overflow;
            end
            if (shift_strobe === 1'b1 && ns < 16) begin
                s_edge[ns] = e;
                s_new[ns]  = digit_new;
                s_old[ns]  = digit_old;
                ns++;
            end
        end
    endtask

    task test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({digit_new, digit_old, shift_strobe, fifo_count, overflow} !== 13'd0) begin
            bad++;
            $display("FAIL reset_hold: outputs=%h want 0", {digit_new, digit_old, shift_strobe, fifo_count, overflow});
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({digit_new, digit_old, shift_strobe, fifo_count, overflow} !== 13'd0 || dut.state_q !== IDLE) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: outputs=%h state=%0d want 0/IDLE", i,
                         {digit_new, digit_old, shift_strobe, fifo_count, overflow}, dut.state_q);
            end
        end
    endtask

    task test_single;
        do_clear();
        key_valid = 1'b1;
        key_code  = 4'h5;
        tick();
        key_valid = 1'b0;
        total++;
        if (fifo_count !== 3'd1 || shift_strobe !== 1'b0) begin
            bad++;
            $display("FAIL single_edge0: count=%0d strobe=%b want 1/0", fifo_count, shift_strobe);
        end
        tick();
        total++;
        if (shift_strobe !== 1'b1 || digit_new !== 4'h5 || digit_old !== 4'h0 || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL single_edge1: strobe=%b new=%h old=%h count=%0d want 1/5/0/0",
                     shift_strobe, digit_new, digit_old, fifo_count);
        end
        tick();
        total++;
        if (shift_strobe !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse: strobe=%b want 0", shift_strobe);
        end
        repeat (6) tick();
    endtask

    task test_burst;
        int exp_e [3];
        logic [3:0] exp_d [3];
        exp_e = '{1, 6, 11};
        exp_d = '{4'h1, 4'h2, 4'h3};
        do_clear();
        seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h3;
        nseq = 3;
        run_seq(16);
        total++;
        if (ns !== 3) begin
            bad++;
            $display("FAIL burst_count: strobes=%0d want 3", ns);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (s_edge[i] !== exp_e[i] || s_new[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL burst_shift%0d: edge=%0d digit=%h want %0d/%h", i, s_edge[i], s_new[i], exp_e[i], exp_d[i]);
            end
        end
        total++;
        if (digit_new !== 4'h3 || digit_old !== 4'h2) begin
            bad++;
            $display("FAIL burst_final: new=%h old=%h want 3/2", digit_new, digit_old);
        end
    endtask

    task test_overflow;
        logic [3:0] exp_d [5];
`ifdef KEY_QUEUE_DROP_OLDEST_EN
        exp_d = '{4'h1, 4'h3, 4'h4, 4'h5, 4'h6};
`else
        exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
`endif
        do_clear();
        for (int i = 0; i < 6; i++) seq[i] = 4'(i + 1);
        nseq = 6;
        run_seq(26);
        total++;
        if (cnt_at5 !== 3'd4 || ovf_at5 !== 1'b1) begin
            bad++;
            $display("FAIL ovf_edge5: count=%0d overflow=%b want 4/1", cnt_at5, ovf_at5);
        end
        total++;
        if (ns !== 5) begin
            bad++;
            $display("FAIL ovf_strobes: strobes=%0d want 5", ns);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (s_new[i] !== exp_d[i] || s_edge[i] !== 1 + 5 * i) begin
                bad++;
                $display("FAIL ovf_order%0d: digit=%h edge=%0d want %h/%0d", i, s_new[i], s_edge[i], exp_d[i], 1 + 5 * i);
            end
        end
        total++;
        if (overflow !== 1'b1 || fifo_count !== 3'd0 || digit_old !== exp_d[3]) begin
            bad++;
            $display("FAIL ovf_final: overflow=%b count=%0d old=%h want 1/0/%h", overflow, fifo_count, digit_old, exp_d[3]);
        end
    endtask

    task test_clear;
        seq[0] = 4'h7; seq[1] = 4'h8; seq[2] = 4'hA;
        nseq = 3;
        run_seq(3);
        total++;
        if (fifo_count !== 3'd2 || overflow !== 1'b1 || digit_new !== 4'h7) begin
            bad++;
            $display("FAIL clear_pre: count=%0d overflow=%b new=%h want 2/1/7", fifo_count, overflow, digit_new);
        end
        clear     = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h9;
        tick();
        clear     = 1'b0;
        key_valid = 1'b0;
        total++;
        if (fifo_count !== 3'd0 || digit_new !== 4'h0 || digit_old !== 4'h0 || overflow !== 1'b0 || shift_strobe !== 1'b0) begin
            bad++;
            $display("FAIL clear_edge: count=%0d new=%h old=%h overflow=%b strobe=%b want all 0",
                     fifo_count, digit_new, digit_old, overflow, shift_strobe);
        end
        nseq = 0;
        run_seq(10);
        total++;
        if (ns !== 0 || digit_new !== 4'h0) begin
            bad++;
            $display("FAIL clear_after: strobes=%0d new=%h want 0/0", ns, digit_new);
        end
    endtask

    task test_reset_mid_hold;
        do_clear();
        key_valid = 1'b1;
        key_code  = 4'h3;
        tick();
        key_valid = 1'b1;
        key_code  = 4'h4;
        tick();
        key_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({digit_new, digit_old, shift_strobe, fifo_count, overflow} !== 13'd0 || dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL midhold_async: outputs=%h state=%0d want 0/IDLE",
                     {digit_new, digit_old, shift_strobe, fifo_count, overflow}, dut.state_q);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        key_valid = 1'b1;
        key_code  = 4'hC;
        tick();
        key_valid = 1'b0;
        total++;
        if (shift_strobe !== 1'b0 || fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL midhold_edge0: strobe=%b count=%0d want 0/1", shift_strobe, fifo_count);
        end
        tick();
        total++;
        if (shift_strobe !== 1'b1 || digit_new !== 4'hC || digit_old !== 4'h0) begin
            bad++;
            $display("FAIL midhold_edge1: strobe=%b new=%h old=%h want 1/c/0", shift_strobe, digit_new, digit_old);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_clear();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
